demux_reg: RTL and testbench

//  Registered 1-to-10 distributor for 9-bit signed words; the write-side counterpart of the
//  10:1 operand select mux. Routes one input word to one of ten held outputs d0..d9 by a
//  4-bit index, pulses a per-output update strobe, and supports a sequenced fill of all ten.

---
 rtl/demux_reg.sv | 147 ++++++++++++++
 tb/tb_demux_reg.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/demux_reg.sv
// Registered 1-to-10 distributor with sequenced fill of all outputs.
// Optional sticky sel_err with err_clr when DEMUX_ERR_STICKY_EN is defined.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   din, sel, wr_en   write data, destination index (0..9), write request
//   rdy               high while IDLE; writes/fills are only accepted then
//   fill_start        start sweep writing fill_val into d0..d9
//   fill_val          fill value, captured when fill_start is accepted
//   d0..d9            held outputs
//   upd               one-hot strobe, bit k high the cycle after d_k changed
//   sel_err           accepted write had sel >= 10
//   err_clr           clears sticky sel_err (DEMUX_ERR_STICKY_EN only)
module demux_reg #(
  parameter int              WIDTH   = 9,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic [3:0]       sel,
  input  logic             wr_en,
  output logic             rdy,
  input  logic             fill_start,
  input  logic [WIDTH-1:0] fill_val,
  output logic [WIDTH-1:0] d0,
  output logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] d4,
  output logic [WIDTH-1:0] d5,
  output logic [WIDTH-1:0] d6,
  output logic [WIDTH-1:0] d7,
  output logic [WIDTH-1:0] d8,
  output logic [WIDTH-1:0] d9,
  output logic [9:0]       upd,
  output logic             sel_err
`ifdef DEMUX_ERR_STICKY_EN
  ,
  input  logic             err_clr
`endif
);

  localparam logic IDLE  = 1'b0;
  localparam logic SWEEP = 1'b1;
  localparam logic [3:0] LAST = 4'd9;

  logic             state;
  logic [3:0]       idx;
  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] d_q [10];

  logic             accept;
  logic             sel_ok;
  logic             bad_wr;
  logic [9:0]       wr_oh;
  logic [9:0]       sw_oh;
  logic [9:0]       upd_nxt;
  logic [WIDTH-1:0] wdata;
  logic             err_nxt;

  assign rdy    = (state == IDLE);
  assign accept = wr_en & rdy;
  assign sel_ok = (sel < 4'd10);
  assign bad_wr = accept & ~sel_ok;

  // At most one destination per cycle: a sweep step and a
  // write can never coincide since writes need IDLE.
  always_comb begin
    wr_oh   = '0;
    sw_oh   = '0;
    upd_nxt = '0;
    wdata   = din;
    if (accept && sel_ok) begin
      wr_oh = 10'd1 << sel;
    end
    if (idx <= LAST) begin
      sw_oh = 10'd1 << idx;
    end
    if (state == SWEEP) begin
      upd_nxt = sw_oh;
      wdata   = cap;
    end else begin
      upd_nxt = wr_oh;
    end
  end

`ifdef DEMUX_ERR_STICKY_EN
  // A fresh error in the clearing cycle wins.
  assign err_nxt = bad_wr | (sel_err & ~err_clr);
`else
  assign err_nxt = bad_wr;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      cap     <= '0;
      upd     <= '0;
      sel_err <= 1'b0;
      for (int k = 0; k < 10; k++) begin
        d_q[k] <= RST_VAL;
      end
    end else begin
      upd     <= upd_nxt;
      sel_err <= err_nxt;
      for (int k = 0; k < 10; k++) begin
        if (upd_nxt[k]) begin
          d_q[k] <= wdata;
        end
      end
      unique case (state)
        IDLE: begin
          if (fill_start) begin
            cap   <= fill_val;
            idx   <= '0;
            state <= SWEEP;
          end
        end
        SWEEP: begin
          if (idx == LAST) begin
            idx   <= '0;
            state <= IDLE;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign d0 = d_q[0];
  assign d1 = d_q[1];
  assign d2 = d_q[2];
  assign d3 = d_q[3];
  assign d4 = d_q[4];
  assign d5 = d_q[5];
  assign d6 = d_q[6];
  assign d7 = d_q[7];
  assign d8 = d_q[8];
  assign d9 = d_q[9];

endmodule

// File: tb/tb_demux_reg.sv
// Testbench for demux_reg: table-driven vectors plus fill,
// collision and abort sequences, checked through a scoreboard queue.
module tb_demux_reg;

`ifdef DEMUX_ERR_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] din;
  logic [3:0] sel;
  logic       wr_en;
  logic       rdy;
  logic       fill_start;
  logic [8:0] fill_val;
  logic [8:0] d0, d1, d2, d3, d4, d5, d6, d7, d8, d9;
  logic [9:0] upd;
  logic       sel_err;
  logic       err_clr;

  always #5 clk = ~clk;

  demux_reg #(.WIDTH(9), .RST_VAL(9'h000)) dut (
    .clk(clk), .rst(rst), .din(din), .sel(sel),
    .wr_en(wr_en), .rdy(rdy), .fill_start(fill_start),
    .fill_val(fill_val),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4),
    .d5(d5), .d6(d6), .d7(d7), .d8(d8), .d9(d9),
    .upd(upd), .sel_err(sel_err)
`ifdef DEMUX_ERR_STICKY_EN
    , .err_clr(err_clr)
`endif
  );

  typedef struct {
    logic [9:0] upd;
    logic       err;
    logic       rdy;
    int         ci;
    logic [8:0] cv;
    logic       all;
    logic [8:0] av;
  } exp_t;

  typedef struct {
    logic       wr;
    logic [3:0] sel;
    logic [8:0] din;
    logic       clr;
    exp_t       e;
  } vec_t;

  exp_t sb[$];
  vec_t vt[12];
  int   nvec = 0;
  int   nfail = 0;

  function automatic exp_t ex(logic [9:0] u, logic er, logic rd,
                              int ci, logic [8:0] cv);
    exp_t e;
    e.upd = u; e.err = er; e.rdy = rd;
    e.ci = ci; e.cv = cv; e.all = 1'b0; e.av = '0;
    return e;
  endfunction

  function automatic exp_t ea(logic [9:0] u, logic er, logic rd,
                              logic [8:0] av);
    exp_t e;
    e = ex(u, er, rd, -1, 9'h0);
    e.all = 1'b1; e.av = av;
    return e;
  endfunction

  function automatic vec_t vv(logic wr, logic [3:0] s, logic [8:0] dn,
                              logic clr, exp_t e);
    vec_t v;
    v.wr = wr; v.sel = s; v.din = dn; v.clr = clr; v.e = e;
    return v;
  endfunction

  function automatic logic [8:0] getd(int k);
    case (k)
      0: return d0;
      1: return d1;
      2: return d2;
      3: return d3;
      4: return d4;
      5: return d5;
      6: return d6;
      7: return d7;
      8: return d8;
      default: return d9;
    endcase
  endfunction

  task automatic chk(string nm, int act, int req);
    nvec++;
    if (act != req) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic drive(logic r, logic wr, logic [3:0] s, logic [8:0] dn,
                       logic fs, logic [8:0] fv, logic clr);
    rst = r; wr_en = wr; sel = s; din = dn;
    fill_start = fs; fill_val = fv; err_clr = clr;
  endtask

  task automatic cycle(exp_t e);
    exp_t x;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("upd", int'(upd), int'(x.upd));
    chk("sel_err", int'(sel_err), int'(x.err));
    chk("rdy", int'(rdy), int'(x.rdy));
    if (x.ci >= 0) begin
      chk($sformatf("d%0d", x.ci), int'(getd(x.ci)), int'(x.cv));
    end
    if (x.all) begin
      for (int k = 0; k < 10; k++) begin
        chk($sformatf("all_d%0d", k), int'(getd(k)), int'(x.av));
      end
    end
  endtask

  initial begin
    vt[0]  = vv(1, 4'd3,  9'h1FB, 0, ex(10'h008, 0, 1, 3, 9'h1FB));
    vt[1]  = vv(1, 4'd9,  9'h0FF, 0, ex(10'h200, 0, 1, 9, 9'h0FF));
    vt[2]  = vv(0, 4'd0,  9'h000, 0, ex(10'h000, 0, 1, 3, 9'h1FB));
    vt[3]  = vv(1, 4'd12, 9'h007, 0, ex(10'h000, 1, 1, 0, 9'h000));
    vt[4]  = vv(0, 4'd0,  9'h000, 0, ex(10'h000, STICKY, 1, 9, 9'h0FF));
    vt[5]  = vv(0, 4'd0,  9'h000, 1, ex(10'h000, 0, 1, 3, 9'h1FB));
    vt[6]  = vv(1, 4'd0,  9'h0AA, 0, ex(10'h001, 0, 1, 0, 9'h0AA));
    vt[7]  = vv(1, 4'd15, 9'h001, 0, ex(10'h000, 1, 1, 0, 9'h0AA));
    vt[8]  = vv(1, 4'd10, 9'h003, 1, ex(10'h000, 1, 1, 2, 9'h000));
    vt[9]  = vv(0, 4'd0,  9'h000, 0, ex(10'h000, STICKY, 1, 2, 9'h000));
    vt[10] = vv(0, 4'd0,  9'h000, 1, ex(10'h000, 0, 1, 9, 9'h0FF));
    vt[11] = vv(1, 4'd5,  9'h100, 0, ex(10'h020, 0, 1, 5, 9'h100));

    // reset held two cycles
    drive(1, 0, 0, 0, 0, 0, 0);
    cycle(ea(10'h0, 0, 1, 9'h000));
    cycle(ea(10'h0, 0, 1, 9'h000));

    for (int i = 0; i < 12; i++) begin
      drive(0, vt[i].wr, vt[i].sel, vt[i].din, 0, 0, vt[i].clr);
      cycle(vt[i].e);
    end

    // fill with -256; late fill_val, fill_start and write ignored
    drive(0, 0, 0, 0, 1, 9'h100, 0);
    cycle(ex(10'h0, 0, 0, -1, 9'h0));
    for (int j = 1; j <= 10; j++) begin
      drive(0, j == 5, 4'd0, 9'h001, j == 3, 9'h055, 0);
      cycle(ex(10'd1 << (j - 1), 0, (j + 1) > 10, j - 1, 9'h100));
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    cycle(ea(10'h0, 0, 1, 9'h100));

    // collision: write d4=17 and fill 2 in the same cycle
    drive(0, 1, 4'd4, 9'd17, 1, 9'd2, 0);
    cycle(ex(10'h010, 0, 0, 4, 9'd17));
    for (int j = 1; j <= 10; j++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      cycle(ex(10'd1 << (j - 1), 0, (j + 1) > 10, j - 1, 9'd2));
    end
    cycle(ea(10'h0, 0, 1, 9'd2));

    // abort: reset in T+4 of a fill
    drive(0, 0, 0, 0, 1, 9'h033, 0);
    cycle(ex(10'h0, 0, 0, -1, 9'h0));
    for (int j = 1; j <= 3; j++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      cycle(ex(10'd1 << (j - 1), 0, 0, j - 1, 9'h033));
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    cycle(ea(10'h0, 0, 1, 9'h000));
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int j = 0; j < 12; j++) begin
      cycle(ea(10'h0, 0, 1, 9'h000));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
